// File: rtl/axis_server_if.sv
// rtl/axis_server_if.sv - NoC-side AXI-Stream style beat interface for axis_server
//
// Purpose: bundles the NoC beat signals delivered to axis_server.
// Signals:
//   tvalid  beat valid (master -> slave)
//   tready  slave can accept beat (slave -> master)
//   tlast   last beat of packet
//   tdest   destination node address
//   tid     packet ID
//   tstrb   byte strobe
//   tkeep   byte keep
//   tuser   source address
//   tdata   beat payload
// Modports: master drives the beat, slave returns tready.
interface axis_server_if #(
  parameter int DATAW = 128,
  parameter int DESTW = 4,
  parameter int IDW   = 32,
  parameter int USERW = 66
);
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [DESTW-1:0] tdest;
  logic [IDW-1:0]   tid;
  logic [7:0]       tstrb;
  logic [7:0]       tkeep;
  logic [USERW-1:0] tuser;
  logic [DATAW-1:0] tdata;

  modport master (
    output tvalid, tlast, tdest, tid, tstrb, tkeep, tuser, tdata,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdest, tid, tstrb, tkeep, tuser, tdata,
    output tready
  );
endinterface

// File: rtl/axis_server.sv
// rtl/axis_server.sv - NoC packet receiver with address filter and FWFT beat buffer
//
// Purpose: accepts NoC packets addressed to MY_ADDR into a DEPTH-entry
// first-word-fall-through buffer and presents them to a consumer; packets
// for other addresses are swallowed and counted.
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   axis_server_interface NoC beat input (slave modport of axis_server_if)
//   server_tdata/tlast    head-of-buffer beat to the consumer
//   server_valid          buffer non-empty
//   server_ready          consumer accepts the head beat
//   pkt_count             packets fully delivered (counted on tlast pop)
//   drop_count            packets discarded for tdest mismatch
module axis_server #(
  parameter int               DATAW   = 128,
  parameter int               DESTW   = 4,
  parameter int               IDW     = 32,
  parameter int               USERW   = 66,
  parameter int               DEPTH   = 8,
  parameter logic [DESTW-1:0] MY_ADDR = DESTW'(4'b0011)
) (
  input  logic               clk,
  input  logic               rst,
  axis_server_if.slave       axis_server_interface,
  output logic [DATAW-1:0]   server_tdata,
  output logic               server_tlast,
  output logic               server_valid,
  input  logic               server_ready,
  output logic [15:0]        pkt_count,
  output logic [15:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e          state_q;
  logic [DATAW:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic [15:0]     pkt_count_q;
  logic [15:0]     drop_count_q;

  logic full;
  logic empty;
  logic tready_w;
  logic accept;
  logic dest_hit;
  logic wr_en;
  logic pop;

  // Sideband fields carried by the NoC but not used by this block.
  logic [IDW-1:0]   unused_tid;
  logic [USERW-1:0] unused_tuser;
  logic [15:0]      unused_strb_keep;
  assign unused_tid       = axis_server_interface.tid;
  assign unused_tuser     = axis_server_interface.tuser;
  assign unused_strb_keep = {axis_server_interface.tstrb, axis_server_interface.tkeep};

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // DROP never writes, so it can always sink beats even when the buffer is full.
  // Held low during reset so nothing is accepted while state is being cleared.
  assign tready_w = !rst && ((state_q == ST_DROP) || !full);
  assign axis_server_interface.tready = tready_w;

  assign accept   = axis_server_interface.tvalid && tready_w;
  assign dest_hit = (axis_server_interface.tdest == MY_ADDR);
  // tdest is only examined on the first beat; body beats follow the header decision.
  assign wr_en    = accept && ((state_q == ST_BODY) || ((state_q == ST_SOP) && dest_hit));
  assign pop      = !empty && server_ready;

  assign count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

  assign server_valid = !empty;
  assign server_tdata = mem_q[rd_ptr_q][DATAW:1];
  assign server_tlast = mem_q[rd_ptr_q][0];
  assign pkt_count    = pkt_count_q;
  assign drop_count   = drop_count_q;

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {axis_server_interface.tdata, axis_server_interface.tlast};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SOP;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (accept) begin
        case (state_q)
          ST_SOP: begin
            if (dest_hit) begin
              state_q <= axis_server_interface.tlast ? ST_SOP : ST_BODY;
            end else begin
              state_q      <= axis_server_interface.tlast ? ST_SOP : ST_DROP;
              drop_count_q <= drop_count_q + 16'd1;
            end
          end
          ST_BODY: if (axis_server_interface.tlast) state_q <= ST_SOP;
          ST_DROP: if (axis_server_interface.tlast) state_q <= ST_SOP;
          default: state_q <= ST_SOP;
        endcase
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (pop && server_tlast) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

endmodule
